// File: rtl/arbiter_pkg.sv
// Shared types for the round-robin descriptor arbiter.
// Descriptor fields are sized for the widest supported build.
package arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    HDR,
    XFER,
    NEXT
  } state_e;

  localparam int STAGE_CONFIG  = 0;
  localparam int STAGE_WEIGHTS = 1;
  localparam int STAGE_ACTS    = 2;

  localparam int DESC_AW = 64;
  localparam int DESC_BW = 16;

  typedef struct packed {
    logic [DESC_AW-1:0] base;
    logic [DESC_AW-1:0] stride;
    logic [DESC_BW-1:0] burst;
  } desc_t;

endpackage

// File: rtl/rr_picker.sv
// One-hot pick of the first pending core after ptr, with wrap.
// ARB_FIXED_PRIORITY_EN: highest pending index wins, ptr ignored.
module rr_picker #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] sel
);

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant = '0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        sel      = PW'(i);
      end
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    sel   = ptr;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && pending[(int'(ptr) + i) % N]) begin
        found                        = 1'b1;
        grant[(int'(ptr) + i) % N]   = 1'b1;
        sel = PW'((int'(ptr) + i) % N);
      end
    end
  end
`endif

endmodule

// File: rtl/arbiter_rr_desc.sv
// Round-robin memory arbiter for PE cores with programmable stage descriptors.
// Build with ARB_FIXED_PRIORITY_EN for legacy highest-index priority.
module arbiter_rr_desc
  import arbiter_pkg::*;
#(
  parameter  int MAIN_MEM_ADDR_WIDTH = 32,
  parameter  int NUM_CORES           = 4,
  parameter  int BURST_WIDTH         = 6,
  parameter  int NUM_READ_STAGES     = 3,
  localparam int STAGE_W = $clog2(NUM_READ_STAGES+1)
) (
  input  logic                           w_clock,
  input  logic                           w_rst_n,
  input  logic                           w_ready,
  input  logic [NUM_CORES-1:0]           w_req,
  output logic [NUM_CORES-1:0]           w_grant,
  output logic                           w_hdr,
  output logic [BURST_WIDTH-1:0]         w_burst,
  output logic                           w_valid,
  output logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr,
  output logic                           w_rw,
  input  logic                           w_mem_ready,
  output logic                           w_done,
  input  logic                           w_cfg_we,
  input  logic [STAGE_W-1:0]             w_cfg_stage,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_cfg_base,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_cfg_stride,
  input  logic [BURST_WIDTH-1:0]         w_cfg_burst
);

  localparam int AW = MAIN_MEM_ADDR_WIDTH;
  localparam int BW = BURST_WIDTH;
  localparam int NC = NUM_CORES;
  localparam int PW = $clog2(NUM_CORES);

  state_e              state_q;
  state_e              state_d;
  logic [NC-1:0]       pending_q;
  logic [NC-1:0]       load_q;
  logic [NC-1:0]       req_d_q;
  logic [NC-1:0]       grant_q;
  logic [PW-1:0]       ptr_q;
  logic [STAGE_W-1:0]  stage_q;
  logic [BW-1:0]       beat_q;
  logic                hdr_q;
  logic                done_q;
  desc_t               cur_q;
  desc_t               desc_q [NUM_READ_STAGES+1];

  logic [NC-1:0]       pick_grant;
  logic [PW-1:0]       pick_sel;
  desc_t               nxt_desc;
  logic                nxt_zero;
  logic [BW-1:0]       cur_burst;
  logic                last_beat;
  logic                beat_ok;
  logic                more;
  logic                finish;
  logic [NC-1:0]       clr;
  logic                unused_desc;

  rr_picker #(.N(NC)) u_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .grant   (pick_grant),
    .sel     (pick_sel)
  );

  assign nxt_desc  = desc_q[stage_q];
  assign nxt_zero  = nxt_desc.burst[BW-1:0] == '0;
  assign cur_burst = cur_q.burst[BW-1:0];
  assign last_beat = beat_q == (cur_burst - BW'(1));
  assign beat_ok   = (state_q == XFER) && !hdr_q
                   && w_mem_ready;
  assign more      = stage_q < STAGE_W'(NUM_READ_STAGES-1);
  assign finish    = (state_q == NEXT) && !more;
  assign clr       = finish ? grant_q : '0;
  assign unused_desc = ^cur_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|pending_q) state_d = ARB;
      ARB:  state_d = HDR;
      HDR:  state_d = nxt_zero ? NEXT : XFER;
      XFER: if (beat_ok && last_beat) state_d = NEXT;
      NEXT: state_d = more ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) state_q <= IDLE;
    else if (w_ready) state_q <= state_d;
  end

  // Descriptor writes are accepted even while w_ready is low.
  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i <= NUM_READ_STAGES; i++)
        desc_q[i] <= '0;
    end else if (w_cfg_we &&
                 int'(w_cfg_stage) <= NUM_READ_STAGES) begin
      desc_q[w_cfg_stage].base   <= DESC_AW'(w_cfg_base);
      desc_q[w_cfg_stage].stride <= DESC_AW'(w_cfg_stride);
      desc_q[w_cfg_stage].burst  <= DESC_BW'(w_cfg_burst);
    end
  end

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      pending_q <= '0;
      load_q    <= '0;
      req_d_q   <= '0;
      grant_q   <= '0;
      ptr_q     <= PW'(NUM_CORES-1);
      stage_q   <= STAGE_W'(STAGE_CONFIG);
      beat_q    <= '0;
      hdr_q     <= 1'b0;
      done_q    <= 1'b0;
      cur_q     <= '0;
    end else if (w_ready) begin
      req_d_q   <= w_req;
      pending_q <= (pending_q & ~clr)
                 | (w_req & ~req_d_q);
      done_q    <= finish;
      hdr_q     <= (state_q == HDR) && !nxt_zero;
      case (state_q)
        ARB: begin
          grant_q <= pick_grant;
          ptr_q   <= pick_sel;
          stage_q <= load_q[pick_sel]
                   ? STAGE_W'(NUM_READ_STAGES)
                   : STAGE_W'(STAGE_CONFIG);
        end
        HDR: begin
          cur_q  <= nxt_desc;
          beat_q <= '0;
        end
        XFER: begin
          if (beat_ok && !last_beat)
            beat_q <= beat_q + BW'(1);
        end
        NEXT: begin
          if (more) begin
            stage_q <= stage_q + STAGE_W'(1);
          end else begin
            load_q[ptr_q] <= ~load_q[ptr_q];
            grant_q       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_grant = grant_q;
  assign w_hdr   = hdr_q;
  assign w_burst = hdr_q ? cur_burst : '0;
  assign w_valid = (state_q == XFER) && !hdr_q;
  assign w_rw    = w_valid
                && (stage_q < STAGE_W'(NUM_READ_STAGES));
  assign w_done  = done_q;
  assign w_addr  = w_valid
                 ? cur_q.base[AW-1:0]
                   + AW'(ptr_q) * cur_q.stride[AW-1:0]
                   + AW'(beat_q)
                 : '0;

endmodule

// File: tb/tb_arbiter_rr_desc.sv
// Directed self-checking bench for arbiter_rr_desc.
// Honours ARB_FIXED_PRIORITY_EN when computing grant order.
module tb_arbiter_rr_desc;

  logic        w_clock;
  logic        w_rst_n;
  logic        w_ready;
  logic [3:0]  w_req;
  logic [3:0]  w_grant;
  logic        w_hdr;
  logic [5:0]  w_burst;
  logic        w_valid;
  logic [31:0] w_addr;
  logic        w_rw;
  logic        w_mem_ready;
  logic        w_done;
  logic        w_cfg_we;
  logic [1:0]  w_cfg_stage;
  logic [31:0] w_cfg_base;
  logic [31:0] w_cfg_stride;
  logic [5:0]  w_cfg_burst;

  arbiter_rr_desc dut (
    .w_clock      (w_clock),
    .w_rst_n      (w_rst_n),
    .w_ready      (w_ready),
    .w_req        (w_req),
    .w_grant      (w_grant),
    .w_hdr        (w_hdr),
    .w_burst      (w_burst),
    .w_valid      (w_valid),
    .w_addr       (w_addr),
    .w_rw         (w_rw),
    .w_mem_ready  (w_mem_ready),
    .w_done       (w_done),
    .w_cfg_we     (w_cfg_we),
    .w_cfg_stage  (w_cfg_stage),
    .w_cfg_base   (w_cfg_base),
    .w_cfg_stride (w_cfg_stride),
    .w_cfg_burst  (w_cfg_burst)
  );

  initial w_clock = 1'b0;
  always #5 w_clock = ~w_clock;

  int errors = 0;
  int checks = 0;
  int ndone  = 0;
  logic [31:0] aq[$];
  logic        rwq[$];
  logic [5:0]  bq[$];
  logic [3:0]  gq[$];
  logic [3:0]  last_g = '0;
  logic [3:0]  exp_g[3];

  always @(negedge w_clock) begin
    if (w_rst_n && w_ready) begin
      if (w_hdr) bq.push_back(w_burst);
      if (w_valid && w_mem_ready) begin
        aq.push_back(w_addr);
        rwq.push_back(w_rw);
      end
      if (w_done) ndone++;
      if (w_grant != 4'b0 && w_grant != last_g)
        gq.push_back(w_grant);
      last_g = w_grant;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clock);
    #1;
  endtask

  task automatic cfg(input int st, input logic [31:0] base,
                     input logic [31:0] stride,
                     input logic [5:0] burst);
    w_cfg_we     = 1'b1;
    w_cfg_stage  = 2'(st);
    w_cfg_base   = base;
    w_cfg_stride = stride;
    w_cfg_burst  = burst;
    tick();
    w_cfg_we = 1'b0;
  endtask

  task automatic clear_q();
    aq.delete();
    rwq.delete();
    bq.delete();
    gq.delete();
  endtask

  task automatic req(input logic [3:0] m);
    w_req = m;
    tick();
    w_req = 4'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int c;
    start = ndone;
    c = 0;
    while (ndone == start && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 64'(ndone - start), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int c;
    c = 0;
    while (!w_valid && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 64'(w_valid), 64'd1);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_grant"}, 64'(w_grant), 64'd0);
    chk({tag, "_hdr"},   64'(w_hdr),   64'd0);
    chk({tag, "_burst"}, 64'(w_burst), 64'd0);
    chk({tag, "_valid"}, 64'(w_valid), 64'd0);
    chk({tag, "_addr"},  64'(w_addr),  64'd0);
    chk({tag, "_rw"},    64'(w_rw),    64'd0);
    chk({tag, "_done"},  64'(w_done),  64'd0);
  endtask

  // Expected read addresses of one load for a core offset off.
  task automatic chk_reads(input string tag, input logic [31:0] off);
    chk({tag, "_nbeats"}, 64'(aq.size()), 64'd12);
    chk({tag, "_nhdr"},   64'(bq.size()), 64'd3);
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < 4; b++)
        if (s*4 + b < aq.size()) begin
          chk($sformatf("%s_addr%0d", tag, s*4+b), 64'(aq[s*4+b]),
              64'(32'h100 * (s+1) + off + 32'(b)));
          chk($sformatf("%s_rw%0d", tag, s*4+b),
              64'(rwq[s*4+b]), 64'd1);
        end
  endtask

  initial begin
    w_rst_n = 1'b0; w_ready = 1'b1; w_req = '0;
    w_mem_ready = 1'b1; w_cfg_we = 1'b0; w_cfg_stage = '0;
    w_cfg_base = '0; w_cfg_stride = '0; w_cfg_burst = '0;
    tick(); tick();
    chk_outs_zero("reset");
    w_rst_n = 1'b1;
    tick();
    cfg(0, 32'h100, 32'h40, 6'd4);
    cfg(1, 32'h200, 32'h40, 6'd4);
    cfg(2, 32'h300, 32'h40, 6'd4);
    cfg(3, 32'h800, 32'h40, 6'd4);

    // Three simultaneous requests from reset pointer.
`ifdef ARB_FIXED_PRIORITY_EN
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
`endif
    clear_q();
    req(4'b1011);
    wait_done("rr1_done0", 200);
    wait_done("rr1_done1", 200);
    wait_done("rr1_done2", 200);
    chk("rr1_ngrants", 64'(gq.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < gq.size())
        chk($sformatf("rr1_grant%0d", i), 64'(gq[i]), 64'(exp_g[i]));
    chk("rr1_nbeats", 64'(aq.size()), 64'd36);

    clear_q();
    req(4'b1011);
    wait_done("rr2_done0", 200);
    wait_done("rr2_done1", 200);
    wait_done("rr2_done2", 200);
    chk("rr2_ngrants", 64'(gq.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < gq.size())
        chk($sformatf("rr2_grant%0d", i), 64'(gq[i]), 64'(exp_g[i]));
    chk("rr2_nbeats", 64'(aq.size()), 64'd12);
    for (int i = 0; i < 12; i++)
      if (i < rwq.size())
        chk($sformatf("rr2_rw%0d", i), 64'(rwq[i]), 64'd0);

    // Core 2 load: latency and read stages.
    clear_q();
    w_req = 4'b0100;
    tick();
    w_req = 4'b0;
    chk("lat_e0_grant", 64'(w_grant), 64'd0);
    tick();
    chk("lat_e1_grant", 64'(w_grant), 64'd0);
    tick();
    chk("lat_e2_grant", 64'(w_grant), 64'h4);
    chk("lat_e2_hdr", 64'(w_hdr), 64'd0);
    tick();
    chk("hdr_strobe", 64'(w_hdr), 64'd1);
    chk("hdr_burst", 64'(w_burst), 64'd4);
    chk("hdr_valid", 64'(w_valid), 64'd0);
    tick();
    chk("beat0_valid", 64'(w_valid), 64'd1);
    chk("beat0_addr", 64'(w_addr), 64'h180);
    chk("beat0_rw", 64'(w_rw), 64'd1);
    wait_done("load_done", 200);
    chk("load_pulse", 64'(w_done), 64'd0);
    chk("load_grant_clr", 64'(w_grant), 64'd0);
    chk_reads("load", 32'h80);
    for (int i = 0; i < 3; i++)
      if (i < bq.size())
        chk($sformatf("load_burst%0d", i), 64'(bq[i]), 64'd4);

    // Core 2 unload: write stage only.
    clear_q();
    req(4'b0100);
    wait_done("unload_done", 200);
    chk("unload_nbeats", 64'(aq.size()), 64'd4);
    chk("unload_nhdr", 64'(bq.size()), 64'd1);
    for (int i = 0; i < 4; i++)
      if (i < aq.size()) begin
        chk($sformatf("unload_addr%0d", i), 64'(aq[i]),
            64'(32'h880 + 32'(i)));
        chk($sformatf("unload_rw%0d", i), 64'(rwq[i]), 64'd0);
      end

    // Memory backpressure, then w_ready freeze.
    clear_q();
    req(4'b0100);
    wait_valid("stall_valid", 50);
    chk("stall_first", 64'(w_addr), 64'h180);
    tick();
    w_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_addr%0d", i), 64'(w_addr), 64'h181);
      chk($sformatf("stall_valid%0d", i), 64'(w_valid), 64'd1);
    end
    w_ready = 1'b0;
    w_mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz_addr%0d", i), 64'(w_addr), 64'h181);
      chk($sformatf("frz_grant%0d", i), 64'(w_grant), 64'h4);
      chk($sformatf("frz_hdr%0d", i), 64'(w_hdr), 64'd0);
    end
    w_ready = 1'b1;
    wait_done("stall_done", 200);
    chk_reads("stall", 32'h80);

    // Skipped weights stage on core 0.
    cfg(1, 32'h200, 32'h40, 6'd0);
    clear_q();
    req(4'b0001);
    wait_done("skip_done", 200);
    chk("skip_nhdr", 64'(bq.size()), 64'd2);
    chk("skip_nbeats", 64'(aq.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < aq.size())
        chk($sformatf("skip_addr%0d", i), 64'(aq[i]),
            64'((i < 4 ? 32'h100 : 32'h2FC) + 32'(i)));

    // Asynchronous reset mid-transfer on core 1.
    clear_q();
    req(4'b0010);
    wait_valid("rst_valid", 50);
    tick();
    w_rst_n = 1'b0;
    #1;
    chk_outs_zero("arst");
    begin
      int d0;
      d0 = ndone;
      tick(); tick();
      w_rst_n = 1'b1;
      clear_q();
      for (int i = 0; i < 6; i++) tick();
      chk("arst_no_done", 64'(ndone - d0), 64'd0);
      chk("arst_idle_grant", 64'(w_grant), 64'd0);
      chk("arst_idle_ngrant", 64'(gq.size()), 64'd0);
    end

    // Cleared descriptors: all stages skipped.
    clear_q();
    req(4'b0010);
    wait_done("empty_done", 100);
    chk("empty_grant", 64'(gq.size() > 0 ? gq[0] : 4'h0), 64'h2);
    chk("empty_nhdr", 64'(bq.size()), 64'd0);
    chk("empty_nbeats", 64'(aq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arbiter_rr_desc.md
Name: arbiter_rr_desc

Overview:
- Parametrised successor to the output-stationary cached arbiter.
- Serves PE-core memory requests with round-robin fairness.
- Per-stage burst/address descriptors are programmed through a config port, not hardcoded.
- Runs NUM_READ_STAGES read stages on load and one psum write stage on unload. Main-memory beats are gated by memory backpressure; bus outputs use a valid strobe instead of tristates.

Parameters:
- MAIN_MEM_ADDR_WIDTH, 32, main memory address width
- NUM_CORES, 4, PE array cores (>=2)
- BURST_WIDTH, 6, burst length width; a burst of 0 skips the stage
- NUM_READ_STAGES, 3, read stages per load (config, weights, acts)
- STAGE_W, $clog2(NUM_READ_STAGES+1), descriptor index width (localparam)

Ports:
- w_clock  in  1  clock
- w_rst_n  in  1  asynchronous active-low reset
- w_ready  in  1  active-high enable; low freezes all state
- w_req  in  NUM_CORES  per-core request, rising-edge captured
- w_grant  out  NUM_CORES  one-hot grant, held for the whole transaction
- w_hdr  out  1  header strobe; w_burst valid
- w_burst  out  BURST_WIDTH  burst length of current stage
- w_valid  out  1  beat strobe; w_addr/w_rw valid
- w_addr  out  MAIN_MEM_ADDR_WIDTH  beat address
- w_rw  out  1  1 = read (core loads), 0 = write (psum unload)
- w_mem_ready  in  1  memory accepts the beat this cycle
- w_done  out  1  one-cycle pulse at end of a core transaction
- w_cfg_we  in  1  descriptor write enable
- w_cfg_stage  in  STAGE_W  descriptor index; index NUM_READ_STAGES = psum write
- w_cfg_base  in  MAIN_MEM_ADDR_WIDTH  stage base address
- w_cfg_stride  in  MAIN_MEM_ADDR_WIDTH  per-core address stride
- w_cfg_burst  in  BURST_WIDTH  stage burst length

Behaviour:
- Reset (async, w_rst_n=0):
  - All outputs 0; state IDLE.
  - pending, load, req_d, rr pointer (=NUM_CORES-1) cleared.
  - Descriptors cleared (burst 0).
  - Reset mid-burst aborts with no completion pulse.
- Request capture: pending |= w_req & ~req_d each enabled cycle. A bit is cleared only when its transaction finishes. A rising edge in the same cycle as its own completion stays pending.
- w_ready=0: no state, counter, pending or output change. Config writes are still accepted.
- Config: w_cfg_we writes the descriptor at w_cfg_stage every cycle. Indices > NUM_READ_STAGES are ignored.
- FSM states are IDLE, ARB, HDR, XFER, NEXT:
  - IDLE: if pending != 0, go to ARB next cycle.
  - ARB (1 cycle):
    - sel = first pending index searched from ptr+1 with wrap.
    - Register w_grant one-hot and ptr = sel.
    - stage = 0 if load[sel]=0, else NUM_READ_STAGES.
    - Go to HDR.
  - HDR:
    - Latch descriptor[stage].
    - If burst=0, go to NEXT with no strobes.
    - Otherwise assert w_hdr for 1 cycle with w_burst, clear beat counter, and go to XFER.
  - XFER:
    - w_valid=1, w_rw = (stage < NUM_READ_STAGES).
    - w_addr = base + sel*stride + beat, truncated mod 2^MAIN_MEM_ADDR_WIDTH.
    - Beat increments only when w_mem_ready=1.
    - Accepted beat burst-1 goes to NEXT.
  - NEXT:
    - A read stage < NUM_READ_STAGES-1 increments stage and goes to HDR.
    - Otherwise (last read stage, or the write stage): toggle load[sel], clear pending[sel] and w_grant, pulse w_done, go to IDLE.
- Latency:
  - req edge to grant is 3 cycles (capture, IDLE, ARB).
  - Grant to first w_hdr is 1 cycle.
  - w_done to next grant is at least 2 cycles.
- Descriptor writes during a stage affect only later HDR latches.
- Simultaneous requests are resolved by round-robin; starvation-free within NUM_CORES transactions.

Optional Feature:
- ARB_FIXED_PRIORITY_EN
- Defined: ARB selects the highest pending index and the rr pointer is unused (legacy priority).
- Undefined: round-robin as above.

Decomposition:
- Package arbiter_pkg holds:
  - state enum (IDLE, ARB, HDR, XFER, NEXT)
  - stage constants (STAGE_CONFIG=0, STAGE_WEIGHTS=1, STAGE_ACTS=2)
  - descriptor struct {base, stride, burst}
- Sub-module rr_picker: combinational masked-priority one-hot pick from pending and ptr. The ARB_FIXED_PRIORITY_EN variant lives inside it.

Test Plan:
- Reset, then program stages 0..3 as burst 4, base 0x100/0x200/0x300/0x800, stride 0x40. Edge on core 2 -> grant=0100; 3×(hdr, burst 4); reads 0x180-0x183, 0x280-0x283, 0x380-0x383; w_done; load[2]=1.
- Second core-2 edge -> single write stage, w_rw=0, addrs 0x880-0x883, load[2]=0.
- Cores 0,1,3 rise in the same cycle -> grants in order 0, 1, 3. Re-request all -> order continues 0, 1, 3 (fixed-priority build: 3, 1, 0).
- Hold w_mem_ready=0 for 3 cycles mid-burst -> w_addr holds, total beats still 4. Hold w_ready=0 -> all outputs frozen.
- Set stage 1 burst=0 -> no hdr/beats for weights; stages 0 and 2 run.
- Assert w_rst_n=0 mid-XFER -> all outputs 0 asynchronously, no w_done. After release, IDLE with pending cleared.
